pll_rst_seq: RTL

Reset sequencer for the pixel-clock PLL, running on the 50 MHz board clock that also feeds the PLL input. Drives the PLL reset, watches the PLL lock output through a synchronizer, retries on lock timeout, and releases a downstream reset only once lock has been held stable. Sits between the board reset and the PLL instance; its `pll_rdy` gates the reset of all pixel-domain logic.

---
 rtl/pll_rst_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: holds the PLL in reset, waits for a synchronized lock, retries on timeout
// and releases pll_rdy once lock is stable. Optional macro PLL_RELOCK_EN: lock loss in RUN re-resets the PLL.
module pll_rst_seq #(
  parameter int RST_HOLD     = 1000,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOCK_STABLE  = 1024,
  parameter int RETRY_MAX    = 3
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       pll_rdy,
  output logic       pll_fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int MAX_AB = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // Reload values make each state last exactly its parameter in cycles.
  localparam logic [CW-1:0] HOLD_LD   = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LD   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LD = CW'(LOCK_STABLE - 1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  logic [1:0]    rst_sync_r;
  logic          rst_rel_s;
  logic          sync1_r;
  logic          lock_s;
  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic [1:0]    retry_r, retry_nx;
  logic [7:0]    loss_r, loss_nx;
  logic          rst_nx, rdy_nx, fail_nx;

  assign rst_rel_s = rst_sync_r[1];
  assign retry_cnt = retry_r;
  assign loss_cnt  = loss_r;

  // Reset release synchronizer: assert asynchronously, release after two clock edges.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_r <= pll_lock;
      lock_s  <= sync1_r;
    end
  end

  // State, counter and registered outputs; held at reset values until release completes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= HOLD;
      cnt_r    <= HOLD_LD;
      retry_r  <= 2'd0;
      loss_r   <= 8'd0;
      pll_rst  <= 1'b1;
      pll_rdy  <= 1'b0;
      pll_fail <= 1'b0;
    end else if (!rst_rel_s) begin
      state_r  <= HOLD;
      cnt_r    <= HOLD_LD;
      retry_r  <= 2'd0;
      loss_r   <= 8'd0;
      pll_rst  <= 1'b1;
      pll_rdy  <= 1'b0;
      pll_fail <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      retry_r  <= retry_nx;
      loss_r   <= loss_nx;
      pll_rst  <= rst_nx;
      pll_rdy  <= rdy_nx;
      pll_fail <= fail_nx;
    end
  end

  // Next-state logic; lock takes priority over timeout expiry in WAIT_LOCK.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    retry_nx = retry_r;
    loss_nx  = loss_r;
    case (state_r)
      HOLD: begin
        if (cnt_r == '0) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = WAIT_LD;
        end else begin
          cnt_nx = cnt_r - CW'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = STABLE_LD;
        end else if (cnt_r == '0) begin
          if ({30'd0, retry_r} < 32'(RETRY_MAX - 1)) begin
            retry_nx = retry_r + 2'd1;
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
          end else begin
            state_nx = FAIL;
            cnt_nx   = '0;
          end
        end else begin
          cnt_nx = cnt_r - CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = WAIT_LD;
        end else if (cnt_r == '0) begin
          state_nx = RUN;
          cnt_nx   = '0;
          retry_nx = 2'd0;
        end else begin
          cnt_nx = cnt_r - CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          if (loss_r != 8'hFF) begin
            loss_nx = loss_r + 8'd1;
          end else begin
            loss_nx = loss_r;
          end
`ifdef PLL_RELOCK_EN
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
          retry_nx = 2'd0;
`else
          state_nx = WAIT_LOCK;
          cnt_nx   = WAIT_LD;
`endif
        end else begin
          state_nx = RUN;
        end
      end
      FAIL: begin
        state_nx = FAIL;
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = HOLD_LD;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state register.
  always_comb begin
    rst_nx  = 1'b0;
    rdy_nx  = 1'b0;
    fail_nx = 1'b0;
    case (state_nx)
      HOLD: rst_nx = 1'b1;
      RUN:  rdy_nx = 1'b1;
      FAIL: begin
        rst_nx  = 1'b1;
        fail_nx = 1'b1;
      end
      default: begin
        rst_nx  = 1'b0;
        rdy_nx  = 1'b0;
        fail_nx = 1'b0;
      end
    endcase
  end

endmodule
